// File: rtl/trng_ctrl_pkg.sv
// Shared FSM encoding and default sizing constants for the TRNG arbiter.
package trng_ctrl_pkg;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEF_REP_LIMIT      = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_DELIVER = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans from last_winner+1 upward, wrapping,
// and returns the first active request as a one-hot vector.
module rr_arbiter
  import trng_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] winner
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((32'(last_winner) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trng_arbiter.sv
// Shares one TRNG among NUM_REQ requesters: round-robin grant, collect, deliver.
// Define TRNG_ARB_HEALTH_EN to enable the repeated-word health test.
module trng_arbiter
  import trng_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned REP_LIMIT      = DEF_REP_LIMIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] valid,
  output logic [31:0]        rnd_data,
  output logic               trng_request,
  input  logic               trng_ready,
  input  logic [31:0]        trng_data,
  output logic               busy,
  output logic               timeout_err,
  output logic               health_fail
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               health_int;

`ifdef TRNG_ARB_HEALTH_EN
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);
  logic [31:0]      prev_q, prev_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             health_q, health_d;
  assign health_int = health_q;
`else
  assign health_int = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req         (req),
    .last_winner (last_q),
    .winner      (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    gnt   = '0;
    valid = '0;
    if (state_q != ST_IDLE)    gnt[win_q]   = 1'b1;
    if (state_q == ST_DELIVER) valid[win_q] = 1'b1;
  end

  assign busy         = (state_q != ST_IDLE);
  assign trng_request = (state_q == ST_COLLECT);
  assign rnd_data     = data_q;
  assign timeout_err  = timeout_q;
  assign health_fail  = health_int;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    timeout_d = timeout_q;
`ifdef TRNG_ARB_HEALTH_EN
    prev_d    = prev_q;
    rep_d     = rep_q;
    health_d  = health_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Waiting for trng_ready to fall lets the TRNG clear between words.
        if ((|req) && !trng_ready && !health_int) begin
          state_d = ST_COLLECT;
          win_d   = win_idx;
          cnt_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (!req[win_q]) begin
          state_d = ST_IDLE;
          last_d  = win_q;
        end else if (trng_ready) begin
`ifdef TRNG_ARB_HEALTH_EN
          // A discarded word leaves last_winner alone so the same owner re-collects.
          if (trng_data == prev_q) begin
            state_d = ST_IDLE;
            rep_d   = rep_q + REP_W'(1);
            if (rep_d == REP_W'(REP_LIMIT)) health_d = 1'b1;
          end else begin
            state_d = ST_DELIVER;
            data_d  = trng_data;
            rep_d   = '0;
          end
`else
          state_d = ST_DELIVER;
          data_d  = trng_data;
`endif
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          last_d    = win_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DELIVER: begin
        state_d = ST_IDLE;
        last_d  = win_q;
`ifdef TRNG_ARB_HEALTH_EN
        prev_d  = data_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
`ifdef TRNG_ARB_HEALTH_EN
      prev_q    <= '0;
      rep_q     <= '0;
      health_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
`ifdef TRNG_ARB_HEALTH_EN
      prev_q    <= prev_d;
      rep_q     <= rep_d;
      health_q  <= health_d;
`endif
    end
  end

endmodule

// File: doc/trng_arbiter.md
TRNG_ARBITER -- requirements
Module: trng_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles in COLLECT before abort.
REQ-003 SHALL have parameter REP_LIMIT, default 3: consecutive rejected words before health failure.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req, input, NUM_REQ: per-requester request, held high until its valid bit pulses.
REQ-007 SHALL have port gnt, output, NUM_REQ: one-hot current owner of the TRNG, or zero.
REQ-008 SHALL have port valid, output, NUM_REQ: one-cycle delivery strobe to the owner.
REQ-009 SHALL have port rnd_data, output, 32: delivered word, meaningful only while a valid bit is high.
REQ-010 SHALL have port trng_request, output, 1: drives the TRNG request input.
REQ-011 SHALL have port trng_ready, input, 1: TRNG word-ready flag.
REQ-012 SHALL have port trng_data, input, 32: TRNG random word.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port timeout_err, output, 1: sticky; set on any COLLECT timeout.
REQ-015 SHALL have port health_fail, output, 1: sticky; set when REP_LIMIT is reached.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, DELIVER.
REQ-017 In IDLE: trng_request=0 and gnt=0; when any req is high, trng_ready=0 and health_fail=0, it SHALL pick the winner round-robin starting at last_winner+1 and move to COLLECT on the next edge.
REQ-018 In COLLECT: trng_request=1 and gnt=one-hot winner; the timeout counter increments each cycle.
REQ-019 In COLLECT with trng_ready=1: it SHALL capture trng_data, deassert trng_request on the same edge, and move to DELIVER.
REQ-020 In DELIVER: valid[winner]=1 for exactly one cycle, rnd_data=captured word, trng_request=0; it SHALL update last_winner and return to IDLE.
REQ-021 Latency from trng_ready high to valid SHALL be exactly 1 cycle.
REQ-022 IDLE SHALL NOT raise trng_request while trng_ready is still high, so the TRNG clears between words.
REQ-023 If req[winner] falls during COLLECT, it SHALL drop trng_request, go to IDLE, emit no valid, and update last_winner.
REQ-024 If the timeout counter reaches TIMEOUT_CYCLES in COLLECT, it SHALL set timeout_err, drop trng_request, go to IDLE with no valid, and update last_winner; the requester stays pending.
REQ-025 If trng_ready and timeout coincide, ready SHALL win (normal capture).
REQ-026 The timeout counter SHALL clear on every entry to COLLECT and SHALL be sized as $clog2(TIMEOUT_CYCLES+1) bits.
REQ-027 Requesters raising req while not granted SHALL simply wait; at most one gnt bit is ever high.

Reset
REQ-028 On rst: state=IDLE; gnt, valid, rnd_data, trng_request, busy, timeout_err and health_fail all 0; last_winner=NUM_REQ-1, so requester 0 has first priority.
REQ-029 rst during COLLECT SHALL drop trng_request on the next edge with no valid emitted.
REQ-030 The sticky flags SHALL be cleared only by rst.

Configuration
REQ-031 Macro TRNG_ARB_HEALTH_EN, when defined, SHALL enable a repetition test: a captured word equal to the previously delivered word (initially 0) is discarded.
REQ-032 On a discarded word it SHALL: increment rep_count, return to IDLE keeping the same winner (no rotation), and re-collect.
REQ-033 With the macro defined, rep_count SHALL clear on any accepted word.
REQ-034 With the macro defined, rep_count reaching REP_LIMIT SHALL set health_fail; all grants then stop until rst.
REQ-035 Without the macro: no comparison is made, health_fail is tied to 0, and the previous-word register is not implemented.

Structure
REQ-036 Package trng_ctrl_pkg SHALL hold the FSM state encoding and the default parameter constants.
REQ-037 Sub-module rr_arbiter SHALL hold the round-robin winner selection (req vector and last_winner in; one-hot winner out; combinational).

Verification
REQ-038 Single requester: req[2]=1 with the TRNG model returning 0xA5A5_1234 after 32 cycles -> gnt=0100, valid[2] one cycle, rnd_data=0xA5A5_1234, then IDLE.
REQ-039 All four requesters high from reset -> grant order 0,1,2,3, each with one valid, and trng_request low for at least 1 cycle between words.
REQ-040 trng_ready stuck at 0 -> trng_request drops after 255 cycles, timeout_err=1, no valid, next requester granted.
REQ-041 With TRNG_ARB_HEALTH_EN, TRNG returning a constant 0x0000_0000 -> three discards, health_fail=1, gnt stays 0 thereafter.
REQ-042 rst asserted at COLLECT cycle 10 -> next cycle all outputs 0; a subsequent req[0] is served normally.
REQ-043 req[1] dropped mid-COLLECT -> trng_request falls on the next edge, no valid[1], and req[2] is granted next.
